// File: rtl/picobus32_fifo_responder.sv
// picobus32_fifo_responder
//   PicoBus32 responder exposing a 4-word register window at BASE_ADDR:
//     +0x0 DATA     write pushes into the FIFO, read pops from it
//     +0x4 STATUS   {14'b0, underflow, overflow, 6'b0, full, empty, count}
//     +0x8 CONTROL  bit0 flush, bit1 clear sticky flags (self-clearing, reads 0)
//     +0xC CHECKSUM mod-2^32 sum of accepted pushes since reset/flush
//   Read data is registered (1-cycle latency) and is zero in any cycle that
//   does not return a read, so it can be OR-combined with other responders.
//
// Ports
//   PicoClk      in   clock
//   PicoRst_n    in   asynchronous active-low reset
//   PicoAddr     in   byte address (bits [1:0] ignored)
//   PicoDataIn   in   write data
//   PicoRd       in   read strobe
//   PicoWr       in   write strobe
//   PicoDataOut  out  registered read data
module picobus32_fifo_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          DEPTH     = 16,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic        PicoClk,
    input  logic        PicoRst_n,
    input  logic [31:0] PicoAddr,
    input  logic [31:0] PicoDataIn,
    input  logic        PicoRd,
    input  logic        PicoWr,
    output logic [31:0] PicoDataOut
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDX_DATA   = 2'd0;
    localparam logic [1:0] IDX_STATUS = 2'd1;
    localparam logic [1:0] IDX_CTRL   = 2'd2;
    localparam logic [1:0] IDX_CSUM   = 2'd3;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   csum_q, csum_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [31:0]   dout_q, dout_d;

    logic          hit;
    logic [1:0]    idx;
    logic          rd_hit, wr_hit;
    logic          empty, full;
    logic          pop_req, push_req;
    logic          pop_ok, push_ok;
    logic          ovf_set, unf_set;
    logic          flush, clr_sticky;
    logic [31:0]   status;

    // Byte-lane bits are not part of the decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^PicoAddr[1:0];

    always_comb begin
        hit     = (PicoAddr[31:4] == BASE_ADDR[31:4]);
        idx     = PicoAddr[3:2];
        rd_hit  = PicoRd & hit;
        wr_hit  = PicoWr & hit;

        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));

        pop_req  = rd_hit & (idx == IDX_DATA);
        push_req = wr_hit & (idx == IDX_DATA);
        pop_ok   = pop_req & ~empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push_ok  = push_req & (~full | pop_ok);
        ovf_set  = push_req & full & ~pop_ok;
        unf_set  = pop_req & empty;

        flush      = wr_hit & (idx == IDX_CTRL) & PicoDataIn[0];
        clr_sticky = wr_hit & (idx == IDX_CTRL) & PicoDataIn[1];

        // Later fields win if DEPTH is large enough for count to reach bit 8.
        status          = '0;
        status[CW-1:0]  = count_q;
        status[8]       = empty;
        status[9]       = full;
        status[16]      = ovf_q;
        status[17]      = unf_q;

        dout_d = '0;
        if (rd_hit) begin
            case (idx)
                IDX_DATA:   dout_d = pop_ok ? mem_q[rd_ptr_q] : 32'h0;
                IDX_STATUS: dout_d = status;
                IDX_CSUM:   dout_d = csum_q;
                default:    dout_d = 32'h0;
            endcase
        end

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        csum_d   = push_ok ? csum_q + PicoDataIn : csum_q;

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            csum_d   = '0;
        end

        // A new event in the clearing cycle keeps its flag set.
        ovf_d = (ovf_q & ~clr_sticky) | ovf_set;
        unf_d = (unf_q & ~clr_sticky) | unf_set;
    end

    always_ff @(posedge PicoClk or negedge PicoRst_n) begin
        if (!PicoRst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            csum_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            csum_q   <= csum_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    // Storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge PicoClk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= PicoDataIn;
        end
    end

    assign PicoDataOut = dout_q;

endmodule
